// File: rtl/if_id_queue_if.sv
// Fetch-to-decode instruction queue handshake bundle.
//   master : fetch/decode side (drives in_*, flush, out_ready; observes the rest)
//   slave  : the queue itself
// Signals:
//   in_valid/in_instr/in_pc/in_ready : enqueue handshake from fetch
//   flush                            : redirect, discards all queued words
//   out_valid/out_instr/out_pc       : head entry presented to decode
//   out_misaligned                   : head PC not word aligned
//   out_ready                        : decode consumes the head
//   count                            : occupied entries, 0..DEPTH
interface if_id_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic            in_ready;
  logic            flush;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [31:0]     out_pc;
  logic            out_misaligned;
  logic            out_ready;
  logic [CntW-1:0] count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_misaligned, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_misaligned, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {instr, pc} pairs between fetch
// and decode. No bypass: a word pushed at an edge is visible at the head only
// after that edge. Flush empties the queue and drops the concurrent word.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, priority over everything
//   bus_io : if_id_queue_if slave modport (handshakes, head, count)
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module if_id_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  bus_io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // Push is gated by full from the current count only, so a pop in the same
  // cycle never frees a slot for the concurrent word.
  assign push  = bus_io.in_valid && !full && !bus_io.flush;
  assign pop   = !empty && bus_io.out_ready && !bus_io.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus_io.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the outputs are masked by empty instead.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem[wr_ptr_q] <= bus_io.in_instr;
      pc_mem[wr_ptr_q]    <= bus_io.in_pc;
    end
  end

  always_comb begin
    bus_io.in_ready       = !full;
    bus_io.out_valid      = !empty;
    bus_io.count          = count_q;
    bus_io.out_instr      = Nop;
    bus_io.out_pc         = '0;
    bus_io.out_misaligned = 1'b0;
    if (!empty) begin
      bus_io.out_instr      = instr_mem[rd_ptr_q];
      bus_io.out_pc         = pc_mem[rd_ptr_q];
      bus_io.out_misaligned = (pc_mem[rd_ptr_q][1:0] != 2'b00);
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized plus directed bench for if_id_queue against a queue-based model.
module tb_if_id_queue;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_id_queue_if #(.DEPTH(DEPTH)) bus ();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: head at index 0, each entry {instr, pc}.
  logic [63:0] model_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the state left by the previous edge, then drive inputs for the next
  // edge and advance the model to what that edge should produce.
  task automatic cycle(input logic r, input logic v, input logic f, input logic ordy,
                       input logic [31:0] pc);
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr;
    logic [31:0] instr;
    bit          can_push, do_pop;
    @(negedge clk);
    exp_valid = (model_q.size() != 0);
    exp_pc    = exp_valid ? model_q[0][31:0]  : 32'h0;
    exp_instr = exp_valid ? model_q[0][63:32] : 32'h0000_0013;
    check_eq("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
    check_eq("out_pc", bus.out_pc, exp_pc);
    check_eq("out_instr", bus.out_instr, exp_instr);
    check_eq("out_misaligned", {31'b0, bus.out_misaligned},
             {31'b0, exp_valid && (exp_pc[1:0] != 2'b00)});
    check_eq("in_ready", {31'b0, bus.in_ready}, {31'b0, model_q.size() != DEPTH});
    check_eq("count", 32'(bus.count), 32'(model_q.size()));

    instr         = $urandom;
    rst           = r;
    bus.in_valid  = v;
    bus.flush     = f;
    bus.out_ready = ordy;
    // Garbage on the data lines when not valid must not matter.
    bus.in_instr  = instr;
    bus.in_pc     = v ? pc : $urandom;

    if (r || f) begin
      model_q.delete();
    end else begin
      can_push = v && (model_q.size() < DEPTH);
      do_pop   = ordy && (model_q.size() > 0);
      if (do_pop)   void'(model_q.pop_front());
      if (can_push) model_q.push_back({instr, pc});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held, then release; first push is in the first rst=0 cycle.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);

    // Basic flow.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h4);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h8);
    idle(1);
    drain();

    // Full, refused fifth word, single pop.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'(16 + 4 * i));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h50);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    idle(1);
    // Refill to full, then pop with a concurrent in_valid.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h60);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h64);
    idle(1);
    drain();

    // Flush with concurrent push and pop.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'(32 + 4 * i));
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h80);
    idle(1);
    drain();

    // Stream across pointer wrap with a misaligned PC.
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 1'b0, (i % 2) == 0, (i == 5) ? 32'h102 : 32'(32'h200 + 4 * i));
    drain();

    // Reset mid-stream with a concurrent push.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h304);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h308);
    idle(1);
    drain();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
      cycle($urandom_range(49) == 0, $urandom_range(9) < 7, $urandom_range(15) == 0,
            $urandom_range(9) < 6, pc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
